// File: rtl/fperm_pipe.sv
// fperm_pipe
//
// FP permute / seed unit for the FP execution cluster. It moves 33-bit
// single lanes around inside the 68-bit internal FP format (copy, swap,
// duplicate, interleave). It can also produce reciprocal and
// reciprocal-square-root seed exponents for the divide/sqrt sequencer.
// Results travel through a stallable pipeline LAT stages deep and drive the
// shared FP result bus through a tri-state output.
//
// Optional feature macro: FPERM_EST_EN
//   defined   : ops 6 (RCP) and 7 (RSQ) produce exponent seeds from B
//   undefined : no seed adders; ops 6/7 return B unchanged (MOV of B)
//
// Internal format:
//   [67:66] type tag (FTYPE_DBL marks a double)
//   double : exponent [65:54], mantissa [53:0], lead bit [53]
//   single : hi lane [65:33] (exp [65:57], lead [56])
//            lo lane [32:0]  (exp [32:24], lead [23])
//
// Parameters:
//   LAT    : pipeline depth in cycles, legal 1..4
//   BIAS_D : double exponent bias
//   BIAS_S : single exponent bias
//
// Ports:
//   clk     : clock; every register updates on the falling edge
//   rst     : synchronous active-high reset; clears all valid bits
//   en      : issue strobe; op/A/B are accepted this cycle
//   hold    : freezes every pipeline stage; en is ignored while high
//   op      : operation code (0 MOV, 1 SWP, 2 DUPL, 3 DUPH,
//             4 ILVL, 5 ILVH, 6 RCP, 7 RSQ)
//   srcB    : unary ops 0-3 take B instead of A
//   A, B    : 68-bit operands
//   res     : result; driven only while res_vld=1, high-Z otherwise
//   res_vld : the last pipeline stage holds a valid result

module fperm_pipe #(
  parameter int          LAT    = 1,
  parameter logic [11:0] BIAS_D = 12'h7FF,
  parameter logic [8:0]  BIAS_S = 9'h0FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hold,
  input  logic [2:0]  op,
  input  logic        srcB,
  input  logic [67:0] A,
  input  logic [67:0] B,
  output logic [67:0] res,
  output logic        res_vld
);

  // Tag encoding used by the FP cluster for a double-precision value.
  localparam logic [1:0] FTYPE_DBL = 2'b11;

  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_SWP  = 3'd1;
  localparam logic [2:0] OP_DUPL = 3'd2;
  localparam logic [2:0] OP_DUPH = 3'd3;
  localparam logic [2:0] OP_ILVL = 3'd4;
  localparam logic [2:0] OP_ILVH = 3'd5;

  logic [67:0] src;
  logic [67:0] seed_res;
  logic [67:0] comb_res;

  // Unary ops read either operand; the lane moves below all use this.
  assign src = srcB ? B : A;

`ifdef FPERM_EST_EN
  // Seed generation. op[0] separates RSQ (7) from RCP (6); RSQ halves the
  // exponent before subtracting it from the bias. The subtraction is
  // deliberately modulo the field width: e=0 for RCP yields BIAS, and
  // exponents above the bias wrap rather than saturate.
  logic        is_dbl;
  logic        is_rsq;
  logic [11:0] dbl_e;
  logic [11:0] dbl_sub;
  logic [11:0] dbl_new;
  logic [8:0]  hi_e;
  logic [8:0]  hi_sub;
  logic [8:0]  hi_new;
  logic [8:0]  lo_e;
  logic [8:0]  lo_sub;
  logic [8:0]  lo_new;

  // Note the format choice comes from A's tag while the output tag is B's;
  // the sequencer uses A to tell us how to interpret B.
  assign is_dbl = (A[67:66] == FTYPE_DBL);
  assign is_rsq = op[0];

  assign dbl_e   = B[65:54];
  assign dbl_sub = is_rsq ? (dbl_e >> 1) : dbl_e;
  assign dbl_new = BIAS_D - dbl_sub;

  assign hi_e    = B[65:57];
  assign hi_sub  = is_rsq ? (hi_e >> 1) : hi_e;
  assign hi_new  = BIAS_S - hi_sub;

  assign lo_e    = B[32:24];
  assign lo_sub  = is_rsq ? (lo_e >> 1) : lo_e;
  assign lo_new  = BIAS_S - lo_sub;

  // Only the lead bit survives in each mantissa; the rest of the seed
  // fraction is refined later by the iteration.
  always_comb begin
    seed_res = '0;
    if (is_dbl) begin
      seed_res = {B[67:66], dbl_new, B[53], 53'd0};
    end else begin
      seed_res = {B[67:66], hi_new, B[56], 23'd0, lo_new, B[23], 23'd0};
    end
  end
`else
  // Without the seed feature, RCP/RSQ collapse to a MOV of B. The bias
  // parameters are still part of the interface but have no consumer.
  logic [20:0] unused_bias;

  assign unused_bias = {BIAS_D, BIAS_S};
  assign seed_res    = B;
`endif

  // Operation select. Interleaves always take the upper half from A and the
  // lower half from B, with A's tag, regardless of srcB.
  always_comb begin
    comb_res = src;
    case (op)
      OP_MOV:  comb_res = src;
      OP_SWP:  comb_res = {src[67:66], src[32:0],  src[65:33]};
      OP_DUPL: comb_res = {src[67:66], src[32:0],  src[32:0]};
      OP_DUPH: comb_res = {src[67:66], src[65:33], src[65:33]};
      OP_ILVL: comb_res = {A[67:66],   A[32:0],    B[32:0]};
      OP_ILVH: comb_res = {A[67:66],   A[65:33],   B[65:33]};
      default: comb_res = seed_res;
    endcase
  end

  logic [67:0]    stage_data [LAT];
  logic [LAT-1:0] stage_vld;

  // Valid chain. The FP cluster clocks this unit on the falling edge, so
  // reset is sampled there too. Reset wins over hold and en, so in-flight
  // ops are discarded even when the pipe is frozen. While hold is high
  // nothing moves and an issue in that cycle is dropped.
  always_ff @(negedge clk) begin
    if (rst) begin
      stage_vld <= '0;
    end else if (!hold) begin
      stage_vld[0] <= en;
      for (int i = 1; i < LAT; i++) begin
        stage_vld[i] <= stage_vld[i-1];
      end
    end
  end

  // Data chain. It is not reset: a stale payload is harmless because its
  // valid bit is clear and the bus is released.
  always_ff @(negedge clk) begin
    if (!hold) begin
      stage_data[0] <= comb_res;
      for (int i = 1; i < LAT; i++) begin
        stage_data[i] <= stage_data[i-1];
      end
    end
  end

  // The result bus is shared with other FP units, so drive it only while
  // this unit owns a valid result.
  assign res_vld = stage_vld[LAT-1];
  assign res     = res_vld ? stage_data[LAT-1] : {68{1'bz}};

endmodule

// File: tb/tb_fperm_pipe.sv
// tb_fperm_pipe
//
// Directed bench for fperm_pipe. Three copies of the unit (LAT = 1, 2, 3)
// share the same stimulus so latency, hold and reset behaviour can be
// compared across depths. Inputs change just after the rising edge, the
// DUT registers on the falling edge, and outputs are sampled just after the
// following rising edge. Seed expectations follow the FPERM_EST_EN build.

module tb_fperm_pipe;

  localparam logic [1:0] DBL = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        hold;
  logic [2:0]  op;
  logic        srcB;
  logic [67:0] a_in;
  logic [67:0] b_in;

  wire  [67:0] res1;
  wire  [67:0] res2;
  wire  [67:0] res3;
  logic        vld1;
  logic        vld2;
  logic        vld3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fperm_pipe #(.LAT(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .op(op), .srcB(srcB),
    .A(a_in), .B(b_in), .res(res1), .res_vld(vld1)
  );

  fperm_pipe #(.LAT(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .op(op), .srcB(srcB),
    .A(a_in), .B(b_in), .res(res2), .res_vld(vld2)
  );

  fperm_pipe #(.LAT(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .op(op), .srcB(srcB),
    .A(a_in), .B(b_in), .res(res3), .res_vld(vld3)
  );

  // One cycle of stimulus. Issuing while hold is high would silently drop
  // the op, so that is reported as a protocol error.
  task automatic applyStimulus(input logic r, input logic e, input logic h,
                               input logic [2:0] o, input logic s,
                               input logic [67:0] a, input logic [67:0] b);
    @(posedge clk);
    #1;
    rst  = r;
    en   = e;
    hold = h;
    op   = o;
    srcB = s;
    a_in = a;
    b_in = b;
    if (e && h && !r) begin
      errors++;
      $display("[TB] FAIL protocol: en asserted while hold=1");
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 68'd0, 68'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [67:0] obs,
                             input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkValid(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Safety net in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [67:0] swp_a;
    logic [67:0] swp_exp;
    logic [67:0] ta;
    logic [67:0] tb;
    logic [2:0]  b2b_op  [6];
    logic        b2b_src [6];
    logic [67:0] b2b_exp [6];
    logic [2:0]  sd_op   [6];
    logic [67:0] sd_a    [6];
    logic [67:0] sd_b    [6];
    logic [67:0] sd_exp  [6];
    logic [67:0] hv;
    logic [67:0] w0;
    logic [67:0] w1;
    logic [67:0] w2;

    rst  = 1'b1;
    en   = 1'b0;
    hold = 1'b0;
    op   = 3'd0;
    srcB = 1'b0;
    a_in = '0;
    b_in = '0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 68'd0, 68'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 68'd0, 68'd0);
    idleCycle();
    checkValid("reset_vld_l1", vld1, 1'b0);
    checkValid("reset_vld_l2", vld2, 1'b0);
    checkValid("reset_vld_l3", vld3, 1'b0);

    // SWP: result one cycle per stage later, valid for one cycle only
    swp_a   = {2'b01, 33'h1_0000_0001, 33'h0_8000_0000};
    swp_exp = {2'b01, 33'h0_8000_0000, 33'h1_0000_0001};
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, swp_a, 68'd0);
    idleCycle();
    checkValid("swp_l1_vld", vld1, 1'b1);
    checkOutput("swp_l1_res", res1, swp_exp);
    checkValid("swp_l2_early", vld2, 1'b0);
    idleCycle();
    checkValid("swp_l1_once", vld1, 1'b0);
    checkValid("swp_l2_vld", vld2, 1'b1);
    checkOutput("swp_l2_res", res2, swp_exp);
    idleCycle();
    checkValid("swp_l3_vld", vld3, 1'b1);
    checkOutput("swp_l3_res", res3, swp_exp);
    checkValid("swp_l2_once", vld2, 1'b0);
    idleCycle();
    checkValid("swp_l3_once", vld3, 1'b0);

    // Back-to-back lane moves: ops 0,2,3,4,5 from A, then SWP from B
    ta = {2'b01, 33'h1_2345_6789, 33'h0_ABCD_EF01};
    tb = {2'b10, 33'h1_1111_2222, 33'h0_3333_4444};
    b2b_op[0] = 3'd0; b2b_src[0] = 1'b0;
    b2b_exp[0] = {2'b01, 33'h1_2345_6789, 33'h0_ABCD_EF01};
    b2b_op[1] = 3'd2; b2b_src[1] = 1'b0;
    b2b_exp[1] = {2'b01, 33'h0_ABCD_EF01, 33'h0_ABCD_EF01};
    b2b_op[2] = 3'd3; b2b_src[2] = 1'b0;
    b2b_exp[2] = {2'b01, 33'h1_2345_6789, 33'h1_2345_6789};
    b2b_op[3] = 3'd4; b2b_src[3] = 1'b0;
    b2b_exp[3] = {2'b01, 33'h0_ABCD_EF01, 33'h0_3333_4444};
    b2b_op[4] = 3'd5; b2b_src[4] = 1'b0;
    b2b_exp[4] = {2'b01, 33'h1_2345_6789, 33'h1_1111_2222};
    b2b_op[5] = 3'd1; b2b_src[5] = 1'b1;
    b2b_exp[5] = {2'b10, 33'h0_3333_4444, 33'h1_1111_2222};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        applyStimulus(1'b0, 1'b1, 1'b0, b2b_op[i], b2b_src[i], ta, tb);
      end else begin
        idleCycle();
      end
      if (i >= 1 && i <= 6) begin
        checkValid($sformatf("b2b_l1_vld_%0d", i - 1), vld1, 1'b1);
        checkOutput($sformatf("b2b_l1_res_%0d", i - 1), res1, b2b_exp[i-1]);
      end
      if (i == 7) begin
        checkValid("b2b_l1_drain", vld1, 1'b0);
      end
      if (i >= 3 && i <= 8) begin
        checkValid($sformatf("b2b_l3_vld_%0d", i - 3), vld3, 1'b1);
        checkOutput($sformatf("b2b_l3_res_%0d", i - 3), res3, b2b_exp[i-3]);
      end
      if (i == 9) begin
        checkValid("b2b_l3_drain", vld3, 1'b0);
      end
    end

    // Seeds: RCP/RSQ on double and paired-single operands
    sd_op[0] = 3'd6; sd_a[0] = {DBL, 66'd0};
    sd_b[0]  = {2'b11, 12'h800, 54'h2A_BCDE_F012_3456};
    sd_op[1] = 3'd7; sd_a[1] = {2'b01, 66'd0};
    sd_b[1]  = {2'b01, 9'h100, 1'b1, 23'h012345, 9'h0FE, 1'b0, 23'h07ABCD};
    sd_op[2] = 3'd6; sd_a[2] = {2'b01, 66'd0};
    sd_b[2]  = {2'b00, 9'h000, 1'b0, 23'h7FFFFF, 9'h1FF, 1'b1, 23'h000001};
    sd_op[3] = 3'd7; sd_a[3] = {DBL, 66'd0};
    sd_b[3]  = {2'b10, 12'hC01, 54'h1F_FFFF_FFFF_FFFF};
    sd_op[4] = 3'd6; sd_a[4] = {DBL, 66'd0};
    sd_b[4]  = 68'h5_5555_5555_5555_5555;
    sd_op[5] = 3'd6; sd_a[5] = {DBL, 66'd0};
    sd_b[5]  = {2'b11, 12'h000, 54'h3F_FFFF_FFFF_FFFF};
`ifdef FPERM_EST_EN
    sd_exp[0] = {2'b11, 12'hFFF, 54'h20_0000_0000_0000};
    sd_exp[1] = {2'b01, 9'h07F, 1'b1, 23'h0, 9'h080, 1'b0, 23'h0};
    sd_exp[2] = {2'b00, 9'h0FF, 1'b0, 23'h0, 9'h100, 1'b1, 23'h0};
    sd_exp[3] = {2'b10, 12'h1FF, 54'h0};
    sd_exp[4] = {2'b01, 12'h2AA, 54'h0};
    sd_exp[5] = {2'b11, 12'h7FF, 54'h20_0000_0000_0000};
`else
    sd_exp[0] = {2'b11, 12'h800, 54'h2A_BCDE_F012_3456};
    sd_exp[1] = {2'b01, 9'h100, 1'b1, 23'h012345, 9'h0FE, 1'b0, 23'h07ABCD};
    sd_exp[2] = {2'b00, 9'h000, 1'b0, 23'h7FFFFF, 9'h1FF, 1'b1, 23'h000001};
    sd_exp[3] = {2'b10, 12'hC01, 54'h1F_FFFF_FFFF_FFFF};
    sd_exp[4] = 68'h5_5555_5555_5555_5555;
    sd_exp[5] = {2'b11, 12'h000, 54'h3F_FFFF_FFFF_FFFF};
`endif
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        applyStimulus(1'b0, 1'b1, 1'b0, sd_op[i], 1'b0, sd_a[i], sd_b[i]);
      end else begin
        idleCycle();
      end
      if (i >= 1) begin
        checkValid($sformatf("seed_vld_%0d", i - 1), vld1, 1'b1);
        checkOutput($sformatf("seed_res_%0d", i - 1), res1, sd_exp[i-1]);
      end
    end
    idleCycle();
    idleCycle();
    idleCycle();

    // Hold: one op in flight, pipe frozen for three cycles
    hv = 68'hA_0123_4567_89AB_CDEF;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, hv, 68'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 68'd0, 68'd0);
    checkValid("hold_l2_vld_h1", vld2, 1'b0);
    checkValid("hold_l1_vld_h1", vld1, 1'b1);
    checkOutput("hold_l1_res_h1", res1, hv);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 68'd0, 68'd0);
    checkValid("hold_l2_vld_h2", vld2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 68'd0, 68'd0);
    checkValid("hold_l2_vld_h3", vld2, 1'b0);
    checkValid("hold_l1_vld_h3", vld1, 1'b1);
    checkOutput("hold_l1_res_h3", res1, hv);
    idleCycle();
    checkValid("hold_l2_vld_rel", vld2, 1'b0);
    idleCycle();
    checkValid("hold_l2_vld_out", vld2, 1'b1);
    checkOutput("hold_l2_res_out", res2, hv);
    checkValid("hold_l1_vld_out", vld1, 1'b0);
    idleCycle();
    checkValid("hold_l3_vld_out", vld3, 1'b1);
    checkOutput("hold_l3_res_out", res3, hv);
    checkValid("hold_l2_once", vld2, 1'b0);
    idleCycle();
    checkValid("hold_l3_once", vld3, 1'b0);

    // Reset with every stage occupied, asserted together with en and hold
    w0 = 68'h1_1111_1111_1111_1111;
    w1 = 68'h2_2222_2222_2222_2222;
    w2 = 68'h3_3333_3333_3333_3333;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, w0, 68'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, w1, 68'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, w2, 68'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, w0, 68'd0);
    checkValid("rst_pre_l3_vld", vld3, 1'b1);
    checkOutput("rst_pre_l3_res", res3, w0);
    checkValid("rst_pre_l1_vld", vld1, 1'b1);
    checkOutput("rst_pre_l1_res", res1, w2);
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkValid($sformatf("rst_flush_l1_%0d", i), vld1, 1'b0);
      checkValid($sformatf("rst_flush_l2_%0d", i), vld2, 1'b0);
      checkValid($sformatf("rst_flush_l3_%0d", i), vld3, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fperm_pipe.md
# fperm_pipe

Parametrised FP permute/seed unit for the FP execution cluster. It performs lane moves on the 68-bit internal FP format: copy, swap, duplicate and interleave of the two 33-bit single lanes. It also generates reciprocal and reciprocal-square-root seed exponents for the divide/sqrt sequencer. Results pass through a configurable-depth, stallable pipeline and drive the shared FP result bus through a tri-state output.

## Interface
Parameters:
- LAT, 1: pipeline depth in cycles, legal 1..4
- BIAS_D, 12'h7FF: double exponent bias
- BIAS_S, 9'h0FF: single exponent bias

Ports:
- clk  in  1  clock; all registers update on the falling edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  issue strobe; op/A/B accepted this cycle
- hold  in  1  freeze all pipeline stages
- op  in  3  operation code
- srcB  in  1  unary ops (0–3) take B instead of A
- A  in  68  operand A
- B  in  68  operand B
- res  out  68  result; driven only when res_vld=1, else high-Z
- res_vld  out  1  final stage holds a valid result

## Operation
Format:
- [67:66] type tag; `ftype_dbl` marks a double.
- Double: exponent e=[65:54], mantissa [53:0], lead bit [53].
- Single: hi lane [65:33] with e=[65:57], lead bit [56]; lo lane [32:0] with e=[32:24], lead bit [23].

Source: S = srcB ? B : A.

Ops:
- 0 MOV: S
- 1 SWP: {S.tag, S.lo, S.hi}
- 2 DUPL: {S.tag, S.lo, S.lo}
- 3 DUPH: {S.tag, S.hi, S.hi}
- 4 ILVL: {A.tag, A.lo, B.lo}
- 5 ILVH: {A.tag, A.hi, B.hi}
- 6 RCP: seed from B, e' = (BIAS − e) mod 2^n
- 7 RSQ: seed from B, e' = (BIAS − (e>>1)) mod 2^n

Seed rules (ops 6/7):
- Output tag = B.tag.
- Lead bit copied from B; all other mantissa bits zero.
- Double vs paired single is selected by A.tag == `ftype_dbl`. The single path computes each lane independently with BIAS_S, 9-bit wrap.

Pipeline:
- Stage 0 captures the combinational result and en on the falling edge when hold=0.
- Stages 1..LAT−1 shift when hold=0.
- hold=1 freezes every stage's data and valid; en is ignored that cycle (no capture, no loss of held data).
- res_vld = valid bit of the last stage; res = last-stage data when res_vld, else Z.

## Timing
- Latency: result for an issue in cycle N is valid in cycle N+LAT, plus one cycle per hold cycle in between.
- Throughput: one op per cycle when hold=0.
- Reset:
  - All valid bits clear on the reset edge; res_vld=0, res=Z.
  - Data registers are not reset.
  - Reset overrides hold and en in the same cycle.
  - Reset mid-flight discards every in-flight op.
- Back-to-back issues emerge in order, one per cycle, with no bubbles.
- Simultaneous hold and en: the issue is dropped, so the issuer must not assert en while hold=1. The bench flags this as a protocol error.
- Exponent wrap: e=0 for RCP gives e'=BIAS, with no saturation.

## Configuration
- FPERM_EST_EN defined: ops 6/7 compute seeds as above.
- Undefined: seed adders are absent and ops 6/7 behave as op 0 with S=B (MOV of B).

## Test plan
- LAT=1, op=1, A={2'b01, 33'h1_0000_0001, 33'h0_8000_0000}: next cycle res={2'b01, 33'h0_8000_0000, 33'h1_0000_0001}, res_vld=1 for exactly one cycle.
- LAT=3, ops 0,2,3,4,5 issued back-to-back: five results appear in cycles N+3..N+7 in order, each bit-exact against the model.
- RCP double, B e=12'h800, lead=1: e'=12'hFFF, mantissa 54'h20_0000_0000_0000. RSQ single, lanes e=9'h100/9'h0FE: e'=9'h07F/9'h080.
- LAT=2 with one op in flight, hold=1 for 3 cycles: res_vld stays low and the stage data is unchanged. Release hold: the result appears 1 cycle later.
- rst asserted with ops in every stage: res_vld=0 and res=Z from the next edge, and no stale result ever emerges.
- Build without FPERM_EST_EN: op=6 with B=68'h5_5555_5555_5555_5555 returns B unchanged after LAT cycles.
